// File: rtl/rx_tlp_splitter.sv
// rx_tlp_splitter: splits received PCIe TLPs into a header stream and a DW-aligned payload stream.
module rx_tlp_splitter #(
    parameter int FIFO_WDTH = 64,
    parameter int DATA_WDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FIFO_WDTH-1:0] in_data,
    input  logic [DATA_WDTH-1:0] in_keep,
    input  logic                 in_last,
    output logic                 hdr_valid,
    input  logic                 hdr_ready,
    output logic [FIFO_WDTH-1:0] hdr_data,
    output logic [DATA_WDTH-1:0] hdr_keep,
    output logic                 hdr_last,
    output logic                 pay_valid,
    input  logic                 pay_ready,
    output logic [FIFO_WDTH-1:0] pay_data,
    output logic [DATA_WDTH-1:0] pay_keep,
    output logic                 pay_last,
    output logic [15:0]          tlp_count,
    output logic                 err_pulse
);
    typedef enum logic [2:0] {IDLE, H1, PAY, FLUSH, DROP} state_t;
    localparam logic [DATA_WDTH-1:0] K2 = {DATA_WDTH{1'b1}};
    localparam logic [DATA_WDTH-1:0] K1 = {{(DATA_WDTH/2){1'b0}}, {(DATA_WDTH/2){1'b1}}};
    state_t state_q, state_d;
    logic is4dw_q, is4dw_d, has_data_q, has_data_d;
    logic [10:0] rem_q, rem_d, rem_n;
    logic [31:0] carry_q, carry_d;
    logic hdr_valid_q, hdr_valid_d, hdr_last_q, hdr_last_d;
    logic [FIFO_WDTH-1:0] hdr_data_q, hdr_data_d;
    logic [DATA_WDTH-1:0] hdr_keep_q, hdr_keep_d;
    logic pay_valid_q, pay_valid_d, pay_last_q, pay_last_d;
    logic [FIFO_WDTH-1:0] pay_data_q, pay_data_d;
    logic [DATA_WDTH-1:0] pay_keep_q, pay_keep_d;
    logic [15:0] cnt_q, cnt_d;
    logic err_q, err_d, accept, two, flush_go, unused_keep;
    assign unused_keep = ^in_keep;
    assign in_ready = reset && (state_q == DROP
        || ((state_q == IDLE || state_q == H1) && (!hdr_valid_q || hdr_ready))
        || (state_q == PAY && (!pay_valid_q || pay_ready)));
    assign accept = in_valid && in_ready;
    assign two = rem_q >= 11'd2;
    assign rem_n = rem_q - (two ? 11'd2 : 11'd1);
    // In 3DW mode the last owed DW may already sit in carry, drained by FLUSH.
    assign flush_go = in_last && !is4dw_q && rem_n == 11'd1;
    always_comb begin
        state_d = state_q;
        is4dw_d = is4dw_q;
        has_data_d = has_data_q;
        rem_d = rem_q;
        carry_d = carry_q;
        hdr_valid_d = hdr_valid_q && !hdr_ready;
        hdr_data_d = hdr_data_q;
        hdr_keep_d = hdr_keep_q;
        hdr_last_d = hdr_last_q;
        pay_valid_d = pay_valid_q && !pay_ready;
        pay_data_d = pay_data_q;
        pay_keep_d = pay_keep_q;
        pay_last_d = pay_last_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (in_data[31]) begin
                    err_d = 1'b1;
                    state_d = in_last ? IDLE : DROP;
                end else begin
                    hdr_valid_d = 1'b1;
                    hdr_data_d = in_data;
                    hdr_keep_d = K2;
                    hdr_last_d = in_last;
                    is4dw_d = in_data[29];
                    has_data_d = in_data[30];
                    rem_d = {in_data[9:0] == 10'd0, in_data[9:0]};
                    err_d = in_last;
                    state_d = in_last ? IDLE : H1;
                end
            end
            H1: if (accept) begin
                hdr_valid_d = 1'b1;
                hdr_data_d = is4dw_q ? in_data : {32'b0, in_data[31:0]};
                hdr_keep_d = is4dw_q ? K2 : K1;
                hdr_last_d = 1'b1;
                carry_d = in_data[63:32];
                if (!has_data_q || (!is4dw_q && rem_q == 11'd1)) begin
                    state_d = !in_last ? DROP : has_data_q ? FLUSH : IDLE;
                    err_d = !in_last;
                    cnt_d = cnt_q + 16'(in_last);
                end else begin
                    state_d = in_last ? IDLE : PAY;
                    err_d = in_last;
                end
            end
            PAY: if (accept) begin
                pay_valid_d = 1'b1;
                pay_data_d = is4dw_q ? in_data : {in_data[31:0], carry_q};
                pay_keep_d = two ? K2 : K1;
                pay_last_d = rem_n == 11'd0 || (in_last && !flush_go);
                carry_d = in_data[63:32];
                rem_d = rem_n;
                if (rem_n == 11'd0) begin
                    state_d = in_last ? IDLE : DROP;
                    err_d = !in_last;
                    cnt_d = cnt_q + 16'(in_last);
                end else if (flush_go) begin
                    state_d = FLUSH;
                    cnt_d = cnt_q + 16'd1;
                end else if (in_last) begin
                    state_d = IDLE;
                    err_d = 1'b1;
                end
            end
            FLUSH: if (!pay_valid_q || pay_ready) begin
                pay_valid_d = 1'b1;
                pay_data_d = {32'b0, carry_q};
                pay_keep_d = K1;
                pay_last_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = (accept && in_last) ? IDLE : DROP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            is4dw_q <= 1'b0;
            has_data_q <= 1'b0;
            rem_q <= '0;
            carry_q <= '0;
            hdr_valid_q <= 1'b0;
            hdr_data_q <= '0;
            hdr_keep_q <= '0;
            hdr_last_q <= 1'b0;
            pay_valid_q <= 1'b0;
            pay_data_q <= '0;
            pay_keep_q <= '0;
            pay_last_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is4dw_q <= is4dw_d;
            has_data_q <= has_data_d;
            rem_q <= rem_d;
            carry_q <= carry_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q <= hdr_data_d;
            hdr_keep_q <= hdr_keep_d;
            hdr_last_q <= hdr_last_d;
            pay_valid_q <= pay_valid_d;
            pay_data_q <= pay_data_d;
            pay_keep_q <= pay_keep_d;
            pay_last_q <= pay_last_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign hdr_valid = hdr_valid_q;
    assign hdr_data = hdr_data_q;
    assign hdr_keep = hdr_keep_q;
    assign hdr_last = hdr_last_q;
    assign pay_valid = pay_valid_q;
    assign pay_data = pay_data_q;
    assign pay_keep = pay_keep_q;
    assign pay_last = pay_last_q;
    assign tlp_count = cnt_q;
    assign err_pulse = err_q;
endmodule

// File: tb/tb_rx_tlp_splitter.sv
// tb_rx_tlp_splitter: directed TLP vectors against hand-computed header/payload beats.
module tb_rx_tlp_splitter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, hdr_ready = 1'b1, pay_ready = 1'b1;
    logic [63:0] in_data = '0;
    logic [7:0] in_keep = 8'hFF;
    logic in_ready, hdr_valid, hdr_last, pay_valid, pay_last, err_pulse;
    logic [63:0] hdr_data, pay_data;
    logic [7:0] hdr_keep, pay_keep;
    logic [15:0] tlp_count;
    int n_chk = 0, n_fail = 0, err_cnt = 0;
    logic [72:0] got_h[$], got_p[$], exp_h[$], exp_p[$];
    bit tog = 1'b0;

    always #5 clk = ~clk;

    rx_tlp_splitter dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_data(hdr_data), .hdr_keep(hdr_keep), .hdr_last(hdr_last),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data), .pay_keep(pay_keep), .pay_last(pay_last),
        .tlp_count(tlp_count), .err_pulse(err_pulse)
    );

    always @(negedge clk) begin
        if (reset && hdr_valid && hdr_ready) got_h.push_back({hdr_last, hdr_keep, hdr_data});
        if (reset && pay_valid && pay_ready) got_p.push_back({pay_last, pay_keep, pay_data});
        if (err_pulse) err_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (tog) pay_ready = !pay_ready;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [72:0] bt(input logic l, input logic [7:0] k, input logic [63:0] d);
        return {l, k, d};
    endfunction

    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("send_rdy", 80'(in_ready), 80'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
    endtask

    task automatic compare(input string tag, input int cnt, input int errs);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "_hn"}, 80'(got_h.size()), 80'(exp_h.size()));
        check({tag, "_pn"}, 80'(got_p.size()), 80'(exp_p.size()));
        for (int i = 0; i < got_h.size() && i < exp_h.size(); i++) check({tag, "_h"}, 80'(got_h[i]), 80'(exp_h[i]));
        for (int i = 0; i < got_p.size() && i < exp_p.size(); i++) check({tag, "_p"}, 80'(got_p[i]), 80'(exp_p[i]));
        check({tag, "_cnt"}, 80'(tlp_count), 80'(cnt));
        check({tag, "_err"}, 80'(err_cnt), 80'(errs));
        got_h.delete(); got_p.delete(); exp_h.delete(); exp_p.delete();
    endtask

    task automatic mrd3();
        send(64'h0000_0001_0000_0001, 1'b0);
        send(64'h5555_5555_ABCD_0010, 1'b1);
        exp_h.push_back(bt(1'b0, 8'hFF, 64'h0000_0001_0000_0001));
        exp_h.push_back(bt(1'b1, 8'h0F, 64'h0000_0000_ABCD_0010));
    endtask

    task automatic mwr3();
        send(64'h1111_2222_4000_0003, 1'b0);
        send(64'hD000_0000_A2A2_A2A2, 1'b0);
        send(64'hD222_2222_D111_1111, 1'b1);
        exp_h.push_back(bt(1'b0, 8'hFF, 64'h1111_2222_4000_0003));
        exp_h.push_back(bt(1'b1, 8'h0F, 64'h0000_0000_A2A2_A2A2));
        exp_p.push_back(bt(1'b0, 8'hFF, 64'hD111_1111_D000_0000));
        exp_p.push_back(bt(1'b1, 8'h0F, 64'h0000_0000_D222_2222));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hv", 80'(hdr_valid), 80'd0);
        check("rst_pv", 80'(pay_valid), 80'd0);
        check("rst_rdy", 80'(in_ready), 80'd0);
        check("rst_cnt", 80'(tlp_count), 80'd0);
        check("rst_err", 80'(err_pulse), 80'd0);
        check("rst_hd", 80'({hdr_last, hdr_keep, hdr_data}), 80'd0);
        check("rst_pd", 80'({pay_last, pay_keep, pay_data}), 80'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        mrd3();
        compare("mrd", 1, 0);
        mwr3();
        compare("mwr3", 2, 0);
        tog = 1'b1;
        send(64'h0000_AAAA_6000_0004, 1'b0);
        send(64'hBBBB_0003_CCCC_0002, 1'b0);
        send(64'hD1D1_D1D1_D0D0_D0D0, 1'b0);
        send(64'hD3D3_D3D3_D2D2_D2D2, 1'b1);
        exp_h.push_back(bt(1'b0, 8'hFF, 64'h0000_AAAA_6000_0004));
        exp_h.push_back(bt(1'b1, 8'hFF, 64'hBBBB_0003_CCCC_0002));
        exp_p.push_back(bt(1'b0, 8'hFF, 64'hD1D1_D1D1_D0D0_D0D0));
        exp_p.push_back(bt(1'b1, 8'hFF, 64'hD3D3_D3D3_D2D2_D2D2));
        compare("mwr4_bp", 3, 0);
        tog = 1'b0;
        pay_ready = 1'b1;
        send(64'h1234_5678_8000_0002, 1'b0);
        send(64'h0000_0000_0000_0001, 1'b0);
        send(64'h0000_0000_0000_0002, 1'b1);
        compare("badfmt", 3, 1);
        mrd3();
        compare("after_bad", 4, 1);
        send(64'h0000_1111_6000_0008, 1'b0);
        send(64'h2222_3333_4444_5555, 1'b0);
        send(64'hD1D1_0001_D0D0_0000, 1'b1);
        exp_h.push_back(bt(1'b0, 8'hFF, 64'h0000_1111_6000_0008));
        exp_h.push_back(bt(1'b1, 8'hFF, 64'h2222_3333_4444_5555));
        exp_p.push_back(bt(1'b1, 8'hFF, 64'hD1D1_0001_D0D0_0000));
        compare("early", 4, 2);
        mrd3();
        compare("after_early", 5, 2);
        send(64'h0000_7777_4000_0001, 1'b0);
        send(64'hD0D0_D0D0_A2A2_A2A2, 1'b1);
        exp_h.push_back(bt(1'b0, 8'hFF, 64'h0000_7777_4000_0001));
        exp_h.push_back(bt(1'b1, 8'h0F, 64'h0000_0000_A2A2_A2A2));
        exp_p.push_back(bt(1'b1, 8'h0F, 64'h0000_0000_D0D0_D0D0));
        compare("mwr3_l1", 6, 2);
        send(64'h0000_AAAA_6000_0004, 1'b0);
        send(64'hBBBB_0003_CCCC_0002, 1'b0);
        send(64'hD1D1_D1D1_D0D0_D0D0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("mid_rst_hv", 80'(hdr_valid), 80'd0);
        check("mid_rst_pv", 80'(pay_valid), 80'd0);
        check("mid_rst_cnt", 80'(tlp_count), 80'd0);
        got_h.delete();
        got_p.delete();
        @(posedge clk);
        #1;
        mwr3();
        compare("post_rst", 1, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
